mem_port_arbiter: RTL

Shares one single-ported unified memory between the instruction-fetch requester (PC/IF stage) and the data-memory requester (MEM stage) of the five-stage pipeline. Grants one access at a time, holds the memory request stable until the memory reports ready, and returns a one-cycle acknowledge with read data to the winning requester. Produces a pipeline stall signal while any request is outstanding. Data accesses have priority, bounded by a starvation guard for fetch.

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose  : shares one single-ported memory between instruction fetch (IF) and data access (MEM).
// Latency  : a request sampled in IDLE at cycle N drives mem_req_o at N+1. It is acked in the first cycle >= N+1 with mem_ready_i.
// Backpress: requesters hold req until their one-cycle ack. stall_o is high while any request is not acked this cycle.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   if_req_i/if_addr_i      fetch request and address
//   if_ack_o/if_data_o      fetch done pulse and instruction (zero when no ack)
//   dm_req_i/dm_we_i        data request and store enable
//   dm_addr_i/dm_wdata_i    data address and store data
//   dm_ack_o/dm_rdata_o     data done pulse and load data (zero when no ack)
//   mem_req_o/mem_we_o      memory request and write enable (registered)
//   mem_addr_o/mem_wdata_o  memory address and write data (registered, held during an access)
//   mem_ready_i/mem_rdata_i memory completes the access this cycle, with read data
//   stall_o                 pipeline stall: some request is pending and not acked this cycle
//   busy_o                  arbiter is not idle
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,

   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_data_o,

   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic              dm_ack_o,
   output logic [DATA_W-1:0] dm_rdata_o,

   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ready_i,
   input  logic [DATA_W-1:0] mem_rdata_i,

   output logic              stall_o,
   output logic              busy_o
);

   localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GNT_IF = 2'd1,
      ST_GNT_DM = 2'd2
   } state_t;

   state_t              state_q,      state_d;
   logic                mem_req_q,    mem_req_d;
   logic                mem_we_q,     mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
   logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;

   logic                grant_if;
   logic                grant_dm;
   logic                go_idle;
   logic                if_waiting;
   logic [CNT_W-1:0]    starve_inc;

   // Acks depend only on the granted state and the memory handshake, so they
   // are mutually exclusive by construction.
   assign if_ack_o   = (state_q == ST_GNT_IF) && mem_ready_i;
   assign dm_ack_o   = (state_q == ST_GNT_DM) && mem_ready_i;
   assign if_data_o  = if_ack_o ? mem_rdata_i : '0;
   assign dm_rdata_o = dm_ack_o ? mem_rdata_i : '0;

   assign stall_o    = (if_req_i && !if_ack_o) || (dm_req_i && !dm_ack_o);
   assign busy_o     = (state_q != ST_IDLE);

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

   assign starve_inc = (starve_cnt_q == CNT_MAX) ? CNT_MAX : starve_cnt_q + CNT_W'(1);

   // Grant decision. In IDLE the data port wins unless fetch has been passed
   // over STARVE_MAX times in a row. In an ack cycle, the acked requester's
   // request counts as consumed, so only the other side can be chained in.
   always_comb begin
      grant_if   = 1'b0;
      grant_dm   = 1'b0;
      go_idle    = 1'b0;
      if_waiting = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if_waiting = if_req_i;
            if (dm_req_i && (starve_cnt_q < CNT_MAX)) begin
               grant_dm = 1'b1;
            end else if (if_req_i) begin
               grant_if = 1'b1;
            end else if (dm_req_i) begin
               grant_dm = 1'b1;
            end
         end
         ST_GNT_IF: begin
            if (mem_ready_i) begin
               if (dm_req_i) grant_dm = 1'b1;
               else          go_idle  = 1'b1;
            end
         end
         ST_GNT_DM: begin
            if (mem_ready_i) begin
               if (if_req_i) grant_if = 1'b1;
               else          go_idle  = 1'b1;
            end
         end
         default: go_idle = 1'b1;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      starve_cnt_d = starve_cnt_q;

      if (grant_dm) begin
         state_d     = ST_GNT_DM;
         mem_req_d   = 1'b1;
         mem_we_d    = dm_we_i;
         mem_addr_d  = dm_addr_i;
         mem_wdata_d = dm_wdata_i;
         // A fetch that is still waiting makes this grant one more pass-over.
         // The fetch request in an IF ack cycle is already served and does not count.
         starve_cnt_d = if_waiting ? starve_inc : '0;
      end else if (grant_if) begin
         state_d      = ST_GNT_IF;
         mem_req_d    = 1'b1;
         mem_we_d     = 1'b0;
         mem_addr_d   = if_addr_i;
         mem_wdata_d  = '0;
         starve_cnt_d = '0;
      end else if (go_idle) begin
         // Address, data and write enable keep their last values. With
         // mem_req_o low they are ignored by the memory.
         state_d   = ST_IDLE;
         mem_req_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

`ifndef SYNTHESIS
   a_ack_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
      !(if_ack_o && dm_ack_o));

   a_req_matches_state: assert property (@(posedge clk_i) disable iff (rst_i)
      mem_req_o == busy_o);

   a_hold_while_waiting: assert property (@(posedge clk_i) disable iff (rst_i)
      (mem_req_o && !mem_ready_i) |=>
         (mem_req_o && $stable(mem_we_o) && $stable(mem_addr_o) && $stable(mem_wdata_o)));
`endif

endmodule
